video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Frame sequencer driven by the captured SFR timing set (hsw/hbp/hact/hfp, v*, htotal/vtotal, mirror).
//  Generates hsync/vsync/de, pixel coordinates and frame/line strobes for the pixel pipeline.
//  Its o_vsync feeds back as the SFR capture strobe.
//  Working copy of the config is reloaded only at frame boundaries, so a frame never sees mid-frame changes.
// PARAMETERS
//  PARAM_WIDTH  16  width of all timing params, counters and coordinates
// PORTS
//  I_CLK           in   1    pixel clock
//  I_RSTN          in   1    reset; asynchronous, active-low
//  i_enable        in   1    run request (level)
//  i_mirror_mode   in   1    captured mirror flag
//  i_hsw/i_hbp/i_hact/i_hfp  in  PW  captured horizontal timing
//  i_vsw/i_vbp/i_vact/i_vfp  in  PW  captured vertical timing
//  i_htotal/i_vtotal         in  PW  captured totals (sum-1)
//  o_hsync/o_vsync out  1    sync pulses, active-high
//  o_de            out  1    active pixel window
//  o_x/o_y         out  PW   active-area coordinates (0 outside de)
//  o_frame_start   out  1    1-cycle pulse at hcnt=0, vcnt=0
//  o_line_start    out  1    1-cycle pulse at hcnt=0 of every line
//  o_busy          out  1    FSM not IDLE
//  o_cfg_err       out  1    sticky: last load attempt rejected
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0, working regs 0.
//  FSM (vertical region): IDLE -> VSW -> VBP -> VACT -> VFP -> (VSW | IDLE).
//  Load:
//   - In IDLE with i_enable=1 at cycle N, params copy into working regs at N+1.
//   - Also at the last pixel of each frame (hcnt==htotal_w && vcnt==vtotal_w) if i_enable=1.
//  Validity:
//   - Load valid iff hsw,hact,vsw,vact != 0 and htotal == hsw+hbp+hact+hfp-1 (PW-bit wrap), same for v.
//   - Invalid load: FSM to/stays IDLE, o_cfg_err=1.
//   - o_cfg_err clears on the next valid load.
//  Counters:
//   - hcnt 0..htotal_w, wraps to 0.
//   - vcnt increments on hcnt wrap, 0..vtotal_w.
//   - First frame: hcnt=vcnt=0 at N+1.
//  Regions (PW-bit unsigned compares):
//   - hsync: hcnt < hsw.
//   - h-active: hsw+hbp <= hcnt < hsw+hbp+hact.
//   - vsync: vcnt < vsw.
//   - v-active: vsw+vbp <= vcnt < vsw+vbp+vact.
//   - FSM state transitions on the line wrap at each vertical region boundary.
//  Output timing:
//   - All outputs registered; values at cycle t describe (hcnt,vcnt) of cycle t.
//   - o_de = h-active & v-active.
//   - o_x = mirror_w ? hact_w-1-xi : xi (xi = hcnt-hsw-hbp); o_y = vcnt-vsw-vbp.
//  Disable:
//   - i_enable=0 mid-frame: frame completes.
//   - At frame end FSM -> IDLE; all outputs 0 next cycle.
//   - Enable re-asserted before frame end: seamless continue.
//  Simultaneous frame end + invalid params: IDLE, o_cfg_err=1, no partial frame.
//  Async reset mid-frame: immediate clear; restart needs i_enable sampled in IDLE.
// CONFIGURATION
//  VTG_FRAME_CNT_EN defined:
//   - Adds output o_frame_cnt[PW-1:0], reset 0.
//   - Increments at each completed frame, wraps at 2^PW-1 -> 0.
//   - Holds in IDLE.
//  VTG_FRAME_CNT_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  vtg_pkg:
//   - FSM state enum (IDLE,VSW,VBP,VACT,VFP).
//   - Region-bound struct.
//   - Default PARAM_WIDTH constant.
//  Sub-module vtg_axis_cnt:
//   - Generic wrap counter plus sync/active region decode.
//   - Instantiated twice (h: advance every cycle; v: advance on h wrap).
//  Top holds the working registers, validity check, FSM and output registers.
// TESTING
//  T1 h=2/3/8/2 htotal=14, v=1/2/4/1 vtotal=7, enable:
//   - line=15 clk, frame=120 clk.
//   - de 8 clk/line on lines 3..6.
//   - o_x 0..7, o_y 0..3.
//  T2 T1 with mirror=1: o_x 7..0 per active line; mirror change mid-frame ignored until next frame.
//  T3 change hact 8->4 (htotal 10) mid-frame: current frame keeps 15-clk lines; next frame 11-clk lines.
//  T4 htotal=13 (inconsistent) at enable:
//   - stays IDLE, o_cfg_err=1, outputs 0.
//   - fix to 14: o_cfg_err=0, frame starts.
//  T5 drop i_enable at vcnt=2: frame ends at cycle 119, then IDLE; o_busy 0 at cycle 120.
//  T6 assert I_RSTN=0 at hcnt=5,vcnt=4: outputs 0 immediately.
//   - VTG_FRAME_CNT_EN: o_frame_cnt 0.
//   - Otherwise: 3 full frames give o_frame_cnt=3.

Source files
------------

// File: rtl/vtg_pkg.sv
// rtl/vtg_pkg.sv - shared types and helpers for the video timing generator
//
// Purpose: frame FSM state enum, region-bound struct and the default width of
//          every timing parameter, counter and coordinate.
// Ports:   none (package).

package vtg_pkg;

   localparam int VTG_PW = 16;

   // Vertical region the frame sequencer is currently scanning.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      VSW  = 3'd1,
      VBP  = 3'd2,
      VACT = 3'd3,
      VFP  = 3'd4
   } vtg_state_e;

   // Region bounds on one axis: sync is [0, sync_end), active is
   // [act_start, act_end). All sums wrap at VTG_PW bits.
   typedef struct packed {
      logic [VTG_PW-1:0] sync_end;
      logic [VTG_PW-1:0] act_start;
      logic [VTG_PW-1:0] act_end;
   } vtg_bounds_t;

   function automatic vtg_bounds_t vtg_bounds(input logic [VTG_PW-1:0] sw,
                                              input logic [VTG_PW-1:0] bp,
                                              input logic [VTG_PW-1:0] act);
      vtg_bounds_t b;
      b.sync_end  = sw;
      b.act_start = sw + bp;
      b.act_end   = sw + bp + act;
      return b;
   endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - video timing bus towards the pixel pipeline
//
// Purpose: groups the registered sync/enable/coordinate/strobe outputs.
// Signals: hsync, vsync, de, x[PW], y[PW], frame_start, line_start
// Modports: master (timing generator drives), slave (pixel pipeline reads).

interface video_timing_gen_if
   import vtg_pkg::*;
#(
   parameter int PW = VTG_PW
);
   logic          hsync;
   logic          vsync;
   logic          de;
   logic [PW-1:0] x;
   logic [PW-1:0] y;
   logic          frame_start;
   logic          line_start;

   modport master (
      output hsync, vsync, de, x, y, frame_start, line_start
   );

   modport slave (
      input hsync, vsync, de, x, y, frame_start, line_start
   );
endinterface

// File: rtl/vtg_axis_cnt.sv
// rtl/vtg_axis_cnt.sv - wrap counter with sync/active region decode for one axis
//
// Purpose: holds one axis position; exposes the count it will take after the
//          next edge and the region decode of that count, so the parent can
//          register outputs that line up with the counter.
// Ports:   I_CLK, I_RSTN  clock, async active-low reset
//          adv            advance this cycle
//          total          last count before wrapping (working value)
//          sw, bp, act    params in force for the next count
//          wrap           advancing from total back to 0
//          cnt_nxt        count after the next edge
//          sync_nxt       cnt_nxt inside sync window
//          act_nxt        cnt_nxt inside active window
//          pos_nxt        cnt_nxt relative to active start
// Note:    region math goes through vtg_bounds_t, so PW must equal VTG_PW.

module vtg_axis_cnt
   import vtg_pkg::*;
#(
   parameter int PW = VTG_PW
) (
   input  logic          I_CLK,
   input  logic          I_RSTN,
   input  logic          adv,
   input  logic [PW-1:0] total,
   input  logic [PW-1:0] sw,
   input  logic [PW-1:0] bp,
   input  logic [PW-1:0] act,
   output logic          wrap,
   output logic [PW-1:0] cnt_nxt,
   output logic          sync_nxt,
   output logic          act_nxt,
   output logic [PW-1:0] pos_nxt
);

   logic [PW-1:0] cnt;
   vtg_bounds_t   b;

   always_comb begin
      b    = vtg_bounds(sw, bp, act);
      wrap = adv && (cnt == total);
      if (!adv)
         cnt_nxt = cnt;
      else if (wrap)
         cnt_nxt = '0;
      else
         cnt_nxt = cnt + PW'(1);
      sync_nxt = cnt_nxt < b.sync_end;
      act_nxt  = (cnt_nxt >= b.act_start) && (cnt_nxt < b.act_end);
      pos_nxt  = cnt_nxt - b.act_start;
   end

   always_ff @(posedge I_CLK or negedge I_RSTN) begin
      if (!I_RSTN)
         cnt <= '0;
      else
         cnt <= cnt_nxt;
   end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - frame sequencer producing sync, de, coordinates and strobes
//
// Purpose: runs frames from a working copy of the captured timing set. The
//          copy is refreshed only when starting from IDLE or on the last pixel
//          of a frame, and only if the set is self-consistent.
// Ports:   I_CLK, I_RSTN            pixel clock, async active-low reset
//          i_enable                 run request (level)
//          i_mirror_mode            captured mirror flag
//          i_hsw/hbp/hact/hfp       captured horizontal timing
//          i_vsw/vbp/vact/vfp       captured vertical timing
//          i_htotal/i_vtotal        captured totals (sum - 1)
//          vid                      video timing bus (master)
//          o_busy                   FSM not IDLE
//          o_cfg_err                sticky: last load attempt rejected
//          o_frame_cnt              completed frames (VTG_FRAME_CNT_EN only)
// Build:   define VTG_FRAME_CNT_EN to add o_frame_cnt.

module video_timing_gen
   import vtg_pkg::*;
#(
   parameter int PARAM_WIDTH = VTG_PW
) (
   input  logic                   I_CLK,
   input  logic                   I_RSTN,
   input  logic                   i_enable,
   input  logic                   i_mirror_mode,
   input  logic [PARAM_WIDTH-1:0] i_hsw,
   input  logic [PARAM_WIDTH-1:0] i_hbp,
   input  logic [PARAM_WIDTH-1:0] i_hact,
   input  logic [PARAM_WIDTH-1:0] i_hfp,
   input  logic [PARAM_WIDTH-1:0] i_vsw,
   input  logic [PARAM_WIDTH-1:0] i_vbp,
   input  logic [PARAM_WIDTH-1:0] i_vact,
   input  logic [PARAM_WIDTH-1:0] i_vfp,
   input  logic [PARAM_WIDTH-1:0] i_htotal,
   input  logic [PARAM_WIDTH-1:0] i_vtotal,
   video_timing_gen_if.master     vid,
   output logic                   o_busy,
`ifdef VTG_FRAME_CNT_EN
   output logic [PARAM_WIDTH-1:0] o_frame_cnt,
`endif
   output logic                   o_cfg_err
);

   localparam int PW = PARAM_WIDTH;

   vtg_state_e    state, state_nxt;
   logic          w_mirror;
   logic [PW-1:0] w_hsw, w_hbp, w_hact, w_htotal;
   logic [PW-1:0] w_vsw, w_vbp, w_vact, w_vtotal;

   logic          running, cfg_ok, load_try, load, last_pix, run_n, de_n;
   logic          n_mirror;
   logic [PW-1:0] n_hsw, n_hbp, n_hact, n_vsw, n_vbp, n_vact;
   vtg_bounds_t   vb;

   logic          h_wrap, h_sync_n, h_act_n;
   logic [PW-1:0] h_cnt_n, h_pos_n;
   logic          v_wrap, v_sync_n, v_act_n;
   logic [PW-1:0] v_cnt_n, v_pos_n;

   always_comb begin
      running  = (state != IDLE);
      cfg_ok   = (i_hsw != '0) && (i_hact != '0) && (i_vsw != '0) && (i_vact != '0)
              && (i_htotal == i_hsw + i_hbp + i_hact + i_hfp - PW'(1))
              && (i_vtotal == i_vsw + i_vbp + i_vact + i_vfp - PW'(1));
      // v only advances on h wrap, so both wrapping together is the last pixel.
      last_pix = h_wrap && v_wrap;
      load_try = i_enable && (!running || last_pix);
      load     = load_try && cfg_ok;

      // Params that describe the pixel after the next edge.
      n_mirror = load ? i_mirror_mode : w_mirror;
      n_hsw    = load ? i_hsw  : w_hsw;
      n_hbp    = load ? i_hbp  : w_hbp;
      n_hact   = load ? i_hact : w_hact;
      n_vsw    = load ? i_vsw  : w_vsw;
      n_vbp    = load ? i_vbp  : w_vbp;
      n_vact   = load ? i_vact : w_vact;
      vb       = vtg_bounds(n_vsw, n_vbp, n_vact);

      state_nxt = state;
      if (!running) begin
         state_nxt = load ? VSW : IDLE;
      end else if (last_pix && !load) begin
         state_nxt = IDLE;
      end else if (h_wrap) begin
         // Region follows the new line number, so zero-length back/front
         // porches are skipped naturally.
         if (v_sync_n)
            state_nxt = VSW;
         else if (v_act_n)
            state_nxt = VACT;
         else if (v_cnt_n < vb.act_start)
            state_nxt = VBP;
         else
            state_nxt = VFP;
      end

      run_n = (state_nxt != IDLE);
      de_n  = run_n && h_act_n && v_act_n;
   end

   vtg_axis_cnt #(.PW(PW)) u_hcnt (
      .I_CLK    (I_CLK),
      .I_RSTN   (I_RSTN),
      .adv      (running),
      .total    (w_htotal),
      .sw       (n_hsw),
      .bp       (n_hbp),
      .act      (n_hact),
      .wrap     (h_wrap),
      .cnt_nxt  (h_cnt_n),
      .sync_nxt (h_sync_n),
      .act_nxt  (h_act_n),
      .pos_nxt  (h_pos_n)
   );

   vtg_axis_cnt #(.PW(PW)) u_vcnt (
      .I_CLK    (I_CLK),
      .I_RSTN   (I_RSTN),
      .adv      (h_wrap),
      .total    (w_vtotal),
      .sw       (n_vsw),
      .bp       (n_vbp),
      .act      (n_vact),
      .wrap     (v_wrap),
      .cnt_nxt  (v_cnt_n),
      .sync_nxt (v_sync_n),
      .act_nxt  (v_act_n),
      .pos_nxt  (v_pos_n)
   );

   always_ff @(posedge I_CLK or negedge I_RSTN) begin
      if (!I_RSTN) begin
         state           <= IDLE;
         w_mirror        <= 1'b0;
         w_hsw           <= '0;
         w_hbp           <= '0;
         w_hact          <= '0;
         w_htotal        <= '0;
         w_vsw           <= '0;
         w_vbp           <= '0;
         w_vact          <= '0;
         w_vtotal        <= '0;
         o_cfg_err       <= 1'b0;
         o_busy          <= 1'b0;
         vid.hsync       <= 1'b0;
         vid.vsync       <= 1'b0;
         vid.de          <= 1'b0;
         vid.x           <= '0;
         vid.y           <= '0;
         vid.frame_start <= 1'b0;
         vid.line_start  <= 1'b0;
`ifdef VTG_FRAME_CNT_EN
         o_frame_cnt     <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (load) begin
            w_mirror <= i_mirror_mode;
            w_hsw    <= i_hsw;
            w_hbp    <= i_hbp;
            w_hact   <= i_hact;
            w_htotal <= i_htotal;
            w_vsw    <= i_vsw;
            w_vbp    <= i_vbp;
            w_vact   <= i_vact;
            w_vtotal <= i_vtotal;
         end
         if (load_try)
            o_cfg_err <= !cfg_ok;
         o_busy          <= run_n;
         vid.hsync       <= run_n && h_sync_n;
         vid.vsync       <= run_n && v_sync_n;
         vid.de          <= de_n;
         vid.x           <= !de_n ? '0 : (n_mirror ? n_hact - PW'(1) - h_pos_n : h_pos_n);
         vid.y           <= de_n ? v_pos_n : '0;
         vid.frame_start <= run_n && (h_cnt_n == '0) && (v_cnt_n == '0);
         vid.line_start  <= run_n && (h_cnt_n == '0);
`ifdef VTG_FRAME_CNT_EN
         if (last_pix)
            o_frame_cnt <= o_frame_cnt + PW'(1);
`endif
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed self-checking bench for video_timing_gen

module tb_video_timing_gen;

   localparam int PW = 16;

   logic          clk = 1'b0;
   logic          rstn;
   logic          enable, mirror;
   logic [PW-1:0] hsw, hbp, hact, hfp, htot, vsw, vbp, vact, vfp, vtot;
   logic          busy, cfg_err;
`ifdef VTG_FRAME_CNT_EN
   logic [PW-1:0] frame_cnt;
`endif

   int n_pass  = 0;
   int n_total = 0;

   logic          cap_hs [0:199];
   logic          cap_vs [0:199];
   logic          cap_de [0:199];
   logic          cap_fs [0:199];
   logic          cap_ls [0:199];
   logic          cap_bz [0:199];
   logic          cap_er [0:199];
   logic [PW-1:0] cap_x  [0:199];
   logic [PW-1:0] cap_y  [0:199];

   always #5 clk = ~clk;

   video_timing_gen_if #(.PW(PW)) vif ();

   video_timing_gen #(.PARAM_WIDTH(PW)) dut (
      .I_CLK         (clk),
      .I_RSTN        (rstn),
      .i_enable      (enable),
      .i_mirror_mode (mirror),
      .i_hsw         (hsw),
      .i_hbp         (hbp),
      .i_hact        (hact),
      .i_hfp         (hfp),
      .i_vsw         (vsw),
      .i_vbp         (vbp),
      .i_vact        (vact),
      .i_vfp         (vfp),
      .i_htotal      (htot),
      .i_vtotal      (vtot),
      .vid           (vif),
      .o_busy        (busy),
`ifdef VTG_FRAME_CNT_EN
      .o_frame_cnt   (frame_cnt),
`endif
      .o_cfg_err     (cfg_err)
   );

   task automatic set_cfg(input int a, b, c, d, t, e, f, g, h, u);
      hsw = PW'(a); hbp = PW'(b); hact = PW'(c); hfp = PW'(d); htot = PW'(t);
      vsw = PW'(e); vbp = PW'(f); vact = PW'(g); vfp = PW'(h); vtot = PW'(u);
   endtask

   task automatic sample(input int i);
      cap_hs[i] = vif.hsync;  cap_vs[i] = vif.vsync; cap_de[i] = vif.de;
      cap_fs[i] = vif.frame_start; cap_ls[i] = vif.line_start;
      cap_x[i]  = vif.x; cap_y[i] = vif.y; cap_bz[i] = busy; cap_er[i] = cfg_err;
   endtask

   // Index 0 is the current sample; later indices one negedge apart.
   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         sample(i);
      end
   endtask

   task automatic wait_fs(input int budget, output int cycles, output bit ok);
      ok = 1'b0;
      cycles = 0;
      while (!ok && cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (vif.frame_start === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      logic [36:0] got;
      rstn = 1'b0; enable = 1'b0; mirror = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      got = {vif.hsync, vif.vsync, vif.de, vif.x, vif.y, vif.frame_start, vif.line_start};
      n_total++;
      if (got !== 37'd0) $display("FAIL reset_outputs got=%h exp=0", got); else n_pass++;
      n_total++;
      if ({busy, cfg_err} !== 2'b00) $display("FAIL reset_status got=%b exp=00", {busy, cfg_err}); else n_pass++;
`ifdef VTG_FRAME_CNT_EN
      n_total++;
      if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); else n_pass++;
`endif
      rstn = 1'b1;
      @(negedge clk);
   endtask

   // T1: 15-clk lines, 8-line frame, de on lines 3..6 at hcnt 5..12.
   task automatic test_basic();
      logic [36:0] got, exp;
      int hc, vc, cnt;
      logic e_de;
      set_cfg(2, 3, 8, 2, 14, 1, 2, 4, 1, 7);
      enable = 1'b1;
      @(negedge clk);
      n_total++;
      if ({vif.frame_start, busy} !== 2'b11)
         $display("FAIL t1_start_latency got=%b exp=11", {vif.frame_start, busy});
      else n_pass++;
      capture(121);
      for (int c = 0; c < 120; c++) begin
         hc = c % 15; vc = c / 15;
         e_de = (hc >= 5) && (hc < 13) && (vc >= 3) && (vc < 7);
         exp = {hc < 2, vc < 1, e_de, e_de ? 16'(hc - 5) : 16'd0, e_de ? 16'(vc - 3) : 16'd0,
                (hc == 0) && (vc == 0), hc == 0};
         got = {cap_hs[c], cap_vs[c], cap_de[c], cap_x[c], cap_y[c], cap_fs[c], cap_ls[c]};
         n_total++;
         if (got !== exp) $display("FAIL t1_cycle%0d got=%h exp=%h", c, got, exp); else n_pass++;
      end
      for (int l = 0; l < 8; l++) begin
         cnt = 0;
         for (int h = 0; h < 15; h++) if (cap_de[l * 15 + h] === 1'b1) cnt++;
         n_total++;
         if (cnt != ((l >= 3 && l <= 6) ? 8 : 0))
            $display("FAIL t1_de_line%0d got=%0d exp=%0d", l, cnt, (l >= 3 && l <= 6) ? 8 : 0);
         else n_pass++;
      end
      n_total++;
      if (cap_fs[120] !== 1'b1) $display("FAIL t1_frame_len got=%b exp=1", cap_fs[120]); else n_pass++;
   endtask

   // T2: mirror loaded at frame boundary; mid-frame change ignored.
   task automatic test_mirror();
      int cyc, hc, vc;
      bit ok;
      mirror = 1'b1;
      wait_fs(200, cyc, ok);
      n_total++;
      if (!ok) $display("FAIL t2_wait_fs got=timeout exp=frame_start"); else n_pass++;
      fork
         capture(120);
         begin repeat (30) @(negedge clk); mirror = 1'b0; end
      join
      for (int c = 45; c < 105; c++) begin
         hc = c % 15; vc = c / 15;
         if (hc >= 5 && hc < 13) begin
            n_total++;
            if (cap_x[c] !== 16'(7 - (hc - 5)))
               $display("FAIL t2_mirror_x c%0d got=%0d exp=%0d", c, cap_x[c], 7 - (hc - 5));
            else n_pass++;
         end
      end
      wait_fs(200, cyc, ok);
      capture(120);
      for (int k = 0; k < 8; k++) begin
         n_total++;
         if (cap_x[50 + k] !== 16'(k))
            $display("FAIL t2_unmirror_x k%0d got=%0d exp=%0d", k, cap_x[50 + k], k);
         else n_pass++;
      end
   endtask

   // T3: hact 8->4 mid-frame takes effect only on the next frame.
   task automatic test_hact_change();
      int cyc, cnt;
      bit ok;
      wait_fs(200, cyc, ok);
      fork
         capture(120);
         begin repeat (20) @(negedge clk); hact = 16'd4; htot = 16'd10; end
      join
      cnt = 0;
      for (int h = 45; h < 60; h++) if (cap_de[h] === 1'b1) cnt++;
      n_total++;
      if ({cap_ls[15], cap_ls[11]} !== 2'b10 || cnt != 8)
         $display("FAIL t3_old_frame got=ls%b de%0d exp=ls10 de8", {cap_ls[15], cap_ls[11]}, cnt);
      else n_pass++;
      wait_fs(200, cyc, ok);
      n_total++;
      if (!ok || cyc != 1) $display("FAIL t3_old_len got=%0d exp=1", cyc); else n_pass++;
      capture(88);
      cnt = 0;
      for (int h = 33; h < 44; h++) if (cap_de[h] === 1'b1) cnt++;
      n_total++;
      if ({cap_ls[11], cap_ls[15]} !== 2'b10 || cnt != 4)
         $display("FAIL t3_new_frame got=ls%b de%0d exp=ls10 de4", {cap_ls[11], cap_ls[15]}, cnt);
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
         n_total++;
         if (cap_x[38 + k] !== 16'(k)) $display("FAIL t3_x k%0d got=%0d exp=%0d", k, cap_x[38 + k], k);
         else n_pass++;
      end
      wait_fs(200, cyc, ok);
      n_total++;
      if (!ok || cyc != 1) $display("FAIL t3_new_len got=%0d exp=1", cyc); else n_pass++;
   endtask

   // T4: inconsistent htotal refused at start, accepted once fixed.
   task automatic test_invalid_start();
      int cyc;
      logic [36:0] got;
      enable = 1'b0;
      cyc = 0;
      while (busy !== 1'b0 && cyc < 300) begin @(negedge clk); cyc++; end
      n_total++;
      if (busy !== 1'b0) $display("FAIL t4_stop got=busy exp=idle"); else n_pass++;
      set_cfg(2, 3, 8, 2, 13, 1, 2, 4, 1, 7);
      enable = 1'b1;
      repeat (3) @(negedge clk);
      got = {vif.hsync, vif.vsync, vif.de, vif.x, vif.y, vif.frame_start, vif.line_start};
      n_total++;
      if ({busy, cfg_err} !== 2'b01 || got !== 37'd0)
         $display("FAIL t4_reject got=bz_er%b out=%h exp=01 out=0", {busy, cfg_err}, got);
      else n_pass++;
      htot = 16'd14;
      @(negedge clk);
      n_total++;
      if ({cfg_err, vif.frame_start, busy} !== 3'b011)
         $display("FAIL t4_accept got=%b exp=011", {cfg_err, vif.frame_start, busy});
      else n_pass++;
   endtask

   // T5: seamless re-enable, then a real disable ending the frame at 119.
   task automatic test_disable();
      int cyc, cnt;
      bit ok;
      fork
         capture(120);
         begin
            repeat (30) @(negedge clk); enable = 1'b0;
            repeat (30) @(negedge clk); enable = 1'b1;
         end
      join
      cnt = 0;
      for (int i = 0; i < 120; i++) if (cap_bz[i] === 1'b1) cnt++;
      wait_fs(200, cyc, ok);
      n_total++;
      if (cnt != 120 || !ok || cyc != 1)
         $display("FAIL t5_seamless got=busy%0d gap%0d exp=busy120 gap1", cnt, cyc);
      else n_pass++;
      fork
         capture(122);
         begin repeat (30) @(negedge clk); enable = 1'b0; end
      join
      n_total++;
      if (cap_de[95] !== 1'b1) $display("FAIL t5_completes got=%b exp=1", cap_de[95]); else n_pass++;
      n_total++;
      if ({cap_bz[119], cap_bz[120], cap_bz[121]} !== 3'b100)
         $display("FAIL t5_busy got=%b exp=100", {cap_bz[119], cap_bz[120], cap_bz[121]});
      else n_pass++;
      n_total++;
      if ({cap_hs[120], cap_vs[120], cap_de[120], cap_x[120], cap_y[120], cap_fs[120], cap_ls[120]} !== 37'd0)
         $display("FAIL t5_idle_outputs got=nonzero exp=0");
      else n_pass++;
   endtask

   // Params turn invalid exactly at the frame end: no new frame, error set.
   task automatic test_invalid_at_end();
      enable = 1'b1;
      @(negedge clk);
      n_total++;
      if (vif.frame_start !== 1'b1) $display("FAIL te_start got=%b exp=1", vif.frame_start); else n_pass++;
      fork
         capture(122);
         begin repeat (10) @(negedge clk); htot = 16'd13; end
      join
      n_total++;
      if ({cap_bz[119], cap_er[119], cap_bz[120], cap_er[120], cap_fs[120], cap_fs[121]} !== 6'b100100)
         $display("FAIL te_invalid_end got=%b exp=100100",
                  {cap_bz[119], cap_er[119], cap_bz[120], cap_er[120], cap_fs[120], cap_fs[121]});
      else n_pass++;
   endtask

   // T6: async reset mid-frame, restart only via enable in IDLE.
   task automatic test_reset_mid();
      int cyc;
      bit ok;
      logic [36:0] got;
      htot = 16'd14;
      wait_fs(50, cyc, ok);
      n_total++;
      if (!ok) $display("FAIL t6_restart got=timeout exp=frame_start"); else n_pass++;
      repeat (65) @(negedge clk);
      n_total++;
      if ({vif.de, vif.x, vif.y} !== {1'b1, 16'd0, 16'd1})
         $display("FAIL t6_pre got=%h exp=%h", {vif.de, vif.x, vif.y}, {1'b1, 16'd0, 16'd1});
      else n_pass++;
      rstn = 1'b0;
      #1;
      got = {vif.hsync, vif.vsync, vif.de, vif.x, vif.y, vif.frame_start, vif.line_start};
      n_total++;
      if (got !== 37'd0 || {busy, cfg_err} !== 2'b00)
         $display("FAIL t6_async_clear got=%h bz_er%b exp=0", got, {busy, cfg_err});
      else n_pass++;
`ifdef VTG_FRAME_CNT_EN
      n_total++;
      if (frame_cnt !== 16'd0) $display("FAIL t6_frame_cnt got=%0d exp=0", frame_cnt); else n_pass++;
`endif
      enable = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      repeat (5) @(negedge clk);
      n_total++;
      if (busy !== 1'b0) $display("FAIL t6_no_autostart got=%b exp=0", busy); else n_pass++;
   endtask

`ifdef VTG_FRAME_CNT_EN
   task automatic test_frame_cnt();
      int cyc;
      bit ok;
      enable = 1'b1;
      wait_fs(50, cyc, ok);
      n_total++;
      if (!ok || frame_cnt !== 16'd0) $display("FAIL fc_start got=%0d exp=0", frame_cnt); else n_pass++;
      for (int f = 0; f < 3; f++) wait_fs(200, cyc, ok);
      n_total++;
      if (!ok || frame_cnt !== 16'd3) $display("FAIL fc_three got=%0d exp=3", frame_cnt); else n_pass++;
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_mirror();
      test_hact_change();
      test_invalid_start();
      test_disable();
      test_invalid_at_end();
      test_reset_mid();
`ifdef VTG_FRAME_CNT_EN
      test_frame_cnt();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
